// File: rtl/asym_bram_pingpong_ctrl.sv
// Ping-pong controller for a wide-write / narrow-read simple-dual-port block RAM.
// The RAM holds two banks of one frame each. The write stream fills one bank
// with wide beats while the read stream drains the other bank as narrow words.
// Bank ownership moves through the per-bank full flags. A bank is handed to the
// reader when its last beat is written. It is handed back to the writer when
// its last narrow word is issued to the RAM.
module asym_bram_pingpong_ctrl #(
    parameter int R_WIDTH      = 16,
    parameter int R_DEPTH      = 12,
    parameter int W_WIDTH      = 96,
    parameter int W_DEPTH      = R_WIDTH * R_DEPTH / W_WIDTH,
    parameter int W_ADDR_WIDTH = $clog2(2 * W_DEPTH),
    parameter int R_ADDR_WIDTH = $clog2(2 * R_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [W_WIDTH-1:0]      s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [R_WIDTH-1:0]      m_data,
    output logic                    m_last,
    output logic                    ram_w_en,
    output logic [W_ADDR_WIDTH-1:0] ram_w_addr,
    output logic [W_WIDTH-1:0]      ram_w_data,
    output logic                    ram_r_en,
    output logic [R_ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [R_WIDTH-1:0]      ram_r_data,
    output logic [1:0]              bank_full,
    output logic                    err
);

    localparam int WC_WIDTH = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
    localparam int RC_WIDTH = (R_DEPTH > 1) ? $clog2(R_DEPTH) : 1;

    localparam logic [WC_WIDTH-1:0]     WC_LAST      = WC_WIDTH'(W_DEPTH - 1);
    localparam logic [RC_WIDTH-1:0]     RC_LAST      = RC_WIDTH'(R_DEPTH - 1);
    localparam logic [W_ADDR_WIDTH-1:0] W_BANK1_BASE = W_ADDR_WIDTH'(W_DEPTH);
    localparam logic [R_ADDR_WIDTH-1:0] R_BANK1_BASE = R_ADDR_WIDTH'(R_DEPTH);

    logic [1:0]          full_q;
    logic [1:0]          full_d;
    logic                wb_q;
    logic [WC_WIDTH-1:0] wc_q;
    logic                rb_q;
    logic [RC_WIDTH-1:0] rc_q;
    logic                m_valid_q;
    logic                m_last_q;
    logic                err_q;

    logic                w_accept;
    logic                w_beat_last;
    logic                w_frame_end;
    logic                r_issue;
    logic                r_word_last;
    logic                r_bank_end;

    // The writer may proceed only while its bank is empty. Reset forces the
    // stream closed so nothing lands in the RAM during reset.
    assign s_ready     = !full_q[wb_q] && !rst;
    assign w_accept    = s_valid && s_ready;
    assign w_beat_last = (wc_q == WC_LAST);
    assign w_frame_end = w_accept && w_beat_last;

    // A new RAM read is issued when the current bank has data and the output
    // slot is free or is being emptied this cycle. The RAM output register
    // doubles as the output data register, so holding off the read enable
    // keeps m_data stable under backpressure.
    assign r_issue     = full_q[rb_q] && (!m_valid_q || m_ready) && !rst;
    assign r_word_last = (rc_q == RC_LAST);
    assign r_bank_end  = r_issue && r_word_last;

    assign ram_w_en   = w_accept;
    assign ram_w_addr = (wb_q ? W_BANK1_BASE : '0) + W_ADDR_WIDTH'(wc_q);
    assign ram_w_data = s_data;

    assign ram_r_en   = r_issue;
    assign ram_r_addr = (rb_q ? R_BANK1_BASE : '0) + R_ADDR_WIDTH'(rc_q);

    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign m_data     = ram_r_data;
    assign bank_full  = full_q;
    assign err        = err_q;

    // Next full flags: the writer sets its bank, the reader clears its bank.
    // Both can happen in one cycle only on different banks.
    always_comb begin
        full_d = full_q;
        if (w_frame_end) begin
            full_d[wb_q] = 1'b1;
        end
        if (r_bank_end) begin
            full_d[rb_q] = 1'b0;
        end
    end

    // Bank ownership register.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 2'b00;
        end else begin
            full_q <= full_d;
        end
    end

    // Write bank and beat counter. The frame length comes from the counter,
    // not from s_last.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q <= 1'b0;
            wc_q <= '0;
        end else if (w_accept) begin
            if (w_beat_last) begin
                wb_q <= ~wb_q;
                wc_q <= '0;
            end else begin
                wc_q <= wc_q + WC_WIDTH'(1);
            end
        end
    end

    // Read bank and word counter, advanced on every RAM read issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_q <= 1'b0;
            rc_q <= '0;
        end else if (r_issue) begin
            if (r_word_last) begin
                rb_q <= ~rb_q;
                rc_q <= '0;
            end else begin
                rc_q <= rc_q + RC_WIDTH'(1);
            end
        end
    end

    // Output valid/last track the RAM's one-cycle read latency. They hold while
    // the consumer stalls and drop once the word is taken with nothing behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (r_issue) begin
            m_valid_q <= 1'b1;
            m_last_q  <= r_word_last;
        end else if (m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end
    end

    // Sticky framing error: s_last must coincide exactly with the final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (w_accept && (s_last != w_beat_last)) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_asym_bram_pingpong_ctrl.sv
// Directed bench for asym_bram_pingpong_ctrl with a behavioural asymmetric RAM.
module tb_asym_bram_pingpong_ctrl;

    localparam int RW    = 16;
    localparam int RD    = 12;
    localparam int WW    = 96;
    localparam int WD    = 2;
    localparam int WAW   = 2;
    localparam int RAW   = 5;
    localparam int RATIO = WW / RW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [WW-1:0]  s_data = '0;
    logic           s_last = 1'b0;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [RW-1:0]  m_data;
    logic           m_last;
    logic           ram_w_en;
    logic [WAW-1:0] ram_w_addr;
    logic [WW-1:0]  ram_w_data;
    logic           ram_r_en;
    logic [RAW-1:0] ram_r_addr;
    logic [RW-1:0]  ram_r_data = '0;
    logic [1:0]     bank_full;
    logic           err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [RW-1:0] rd_data_q[$];
    logic          rd_last_q[$];
    int            rd_cyc_q[$];
    int            ra_q[$];
    int            ra_cyc_q[$];

    logic [WW-1:0] mem [0:2*WD-1];

    bit            stall_chk  = 1'b0;
    logic          prev_stall = 1'b0;
    logic [RW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    int t_last;
    int cidx;
    int acc_addr[2];
    int acc_cyc[2];
    int guard;

    asym_bram_pingpong_ctrl #(
        .R_WIDTH(RW), .R_DEPTH(RD), .W_WIDTH(WW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data),
        .bank_full(bank_full), .err(err)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp observed events.
    always @(posedge clk) cyc <= cyc + 1;

    // Asymmetric RAM: wide writes, narrow registered reads, LS lane first.
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
        if (ram_r_en) ram_r_data <= mem[ram_r_addr / RATIO][(ram_r_addr % RATIO) * RW +: RW];
    end

    task automatic checkOutput(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records issued read addresses and accepted words; checks stall stability.
    always @(negedge clk) begin
        if (ram_r_en) begin
            ra_q.push_back(int'(ram_r_addr));
            ra_cyc_q.push_back(cyc);
        end
        if (m_valid && m_ready) begin
            rd_data_q.push_back(m_data);
            rd_last_q.push_back(m_last);
            rd_cyc_q.push_back(cyc);
        end
        if (stall_chk) begin
            if (prev_stall) begin
                checkOutput("stall_data", WW'(m_data), WW'(prev_data));
                checkOutput("stall_last", WW'(m_last), WW'(prev_last));
            end
            if (m_valid && !m_ready) checkOutput("stall_ren", WW'(ram_r_en), '0);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    end

    // Timeout guard in case the design stops handshaking.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [WW-1:0] make_beat(input int base);
        logic [WW-1:0] w;
        w = '0;
        for (int j = 0; j < WW / 8; j++) w[8*j +: 8] = 8'(base + j);
        return w;
    endfunction

    function automatic logic [RW-1:0] exp_word(input int b0, input int b1, input int k);
        int bb;
        bb = ((k < RATIO) ? b0 : b1) + 2 * (k % RATIO);
        return {8'(bb + 1), 8'(bb)};
    endfunction

    task automatic applyStimulus(input logic v, input logic [WW-1:0] d, input logic l, input logic mr);
        @(posedge clk);
        #1;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = mr;
    endtask

    task automatic clear_mon();
        rd_data_q.delete();
        rd_last_q.delete();
        rd_cyc_q.delete();
        ra_q.delete();
        ra_cyc_q.delete();
    endtask

    task automatic check_frame(input string tag, input int b0, input int b1, input int first);
        if (rd_data_q.size() < first + RD) begin
            checkOutput({tag, "_count"}, WW'(rd_data_q.size()), WW'(first + RD));
        end else begin
            for (int k = 0; k < RD; k++) begin
                checkOutput({tag, "_data"}, WW'(rd_data_q[first + k]), WW'(exp_word(b0, b1, k)));
                checkOutput({tag, "_last"}, WW'(rd_last_q[first + k]), WW'(k == RD - 1));
            end
        end
    endtask

    task automatic idle(input int n, input logic mr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, 1'b0, mr);
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset held with s_valid asserted.
        $display("[TB] test: reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, make_beat(1), 1'b0, 1'b0);
            rst = 1'b1;
            @(negedge clk);
            checkOutput("rst_wen", WW'(ram_w_en), '0);
            checkOutput("rst_sready", WW'(s_ready), '0);
            checkOutput("rst_mvalid", WW'(m_valid), '0);
            checkOutput("rst_full", WW'(bank_full), '0);
            checkOutput("rst_err", WW'(err), '0);
            checkOutput("rst_ren", WW'(ram_r_en), '0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_sready", WW'(s_ready), 96'd1);
        checkOutput("post_rst_mlast", WW'(m_last), '0);

        // Single frame, free-running consumer.
        $display("[TB] test: single frame");
        clear_mon();
        applyStimulus(1'b1, make_beat(10), 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("sf_wen0", WW'(ram_w_en), 96'd1);
        checkOutput("sf_waddr0", WW'(ram_w_addr), 96'd0);
        applyStimulus(1'b1, make_beat(30), 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("sf_waddr1", WW'(ram_w_addr), 96'd1);
        t_last = cyc;
        idle(16, 1'b1);
        checkOutput("sf_nwords", WW'(rd_data_q.size()), WW'(RD));
        checkOutput("sf_naddr", WW'(ra_q.size()), WW'(RD));
        if (rd_cyc_q.size() == RD) begin
            checkOutput("sf_first_cyc", WW'(rd_cyc_q[0]), WW'(t_last + 2));
            checkOutput("sf_last_cyc", WW'(rd_cyc_q[RD-1]), WW'(t_last + 2 + RD - 1));
        end
        if (ra_q.size() == RD) begin
            for (int k = 0; k < RD; k++) checkOutput("sf_raddr", WW'(ra_q[k]), WW'(k));
        end
        check_frame("sf", 10, 30, 0);
        checkOutput("sf_err", WW'(err), '0);

        // Backpressure on the second bank.
        $display("[TB] test: backpressure");
        clear_mon();
        applyStimulus(1'b1, make_beat(50), 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_waddr0", WW'(ram_w_addr), 96'd2);
        applyStimulus(1'b1, make_beat(70), 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bp_waddr1", WW'(ram_w_addr), 96'd3);
        stall_chk = 1'b1;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0, '0, 1'b0, (i % 3) == 0);
            @(negedge clk);
        end
        stall_chk = 1'b0;
        checkOutput("bp_nwords", WW'(rd_data_q.size()), WW'(RD));
        if (ra_q.size() == RD) begin
            for (int k = 0; k < RD; k++) checkOutput("bp_raddr", WW'(ra_q[k]), WW'(RD + k));
        end else begin
            checkOutput("bp_naddr", WW'(ra_q.size()), WW'(RD));
        end
        check_frame("bp", 50, 70, 0);

        // Ping-pong: two frames fill both banks, a third waits.
        $display("[TB] test: ping-pong");
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        clear_mon();
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, make_beat((b < 2 ? 100 : 130) + 12 * (b % 2)), (b % 2) == 1, 1'b0);
            @(negedge clk);
            checkOutput("pp_sready", WW'(s_ready), 96'd1);
            checkOutput("pp_waddr", WW'(ram_w_addr), WW'(b));
        end
        applyStimulus(1'b1, make_beat(160), 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pp_full", WW'(bank_full), 96'd3);
        checkOutput("pp_blocked", WW'(s_ready), '0);
        checkOutput("pp_blocked_wen", WW'(ram_w_en), '0);
        cidx = 0;
        for (int i = 0; i < 45; i++) begin
            applyStimulus(cidx < 2, make_beat(cidx == 0 ? 160 : 172), cidx == 1, 1'b1);
            @(negedge clk);
            if (cidx < 2 && s_valid && s_ready) begin
                acc_addr[cidx] = int'(ram_w_addr);
                acc_cyc[cidx]  = cyc;
                cidx++;
            end
        end
        checkOutput("pp_c_beats", WW'(cidx), 96'd2);
        checkOutput("pp_enough_words", WW'(rd_data_q.size() >= 2 * RD), 96'd1);
        checkOutput("pp_enough_addrs", WW'(ra_q.size() >= 2 * RD), 96'd1);
        if (rd_data_q.size() >= 2 * RD) begin
            check_frame("pp_b0", 100, 112, 0);
            check_frame("pp_b1", 130, 142, RD);
            for (int k = 1; k < 2 * RD; k++) checkOutput("pp_nobubble", WW'(rd_cyc_q[k] - rd_cyc_q[0]), WW'(k));
        end
        if (ra_q.size() >= 2 * RD && cidx == 2) begin
            for (int k = 0; k < 2 * RD; k++) checkOutput("pp_raddr", WW'(ra_q[k]), WW'(k));
            checkOutput("pp_c0_cyc", WW'(acc_cyc[0]), WW'(ra_cyc_q[RD-1] + 1));
            checkOutput("pp_c0_addr", WW'(acc_addr[0]), 96'd0);
            checkOutput("pp_c1_addr", WW'(acc_addr[1]), 96'd1);
        end

        // Misplaced s_last sets the sticky error; frame still completes.
        $display("[TB] test: s_last error");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("er_clear", WW'(err), '0);
        clear_mon();
        applyStimulus(1'b1, make_beat(60), 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("er_before", WW'(err), '0);
        applyStimulus(1'b1, make_beat(80), 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("er_set", WW'(err), 96'd1);
        idle(16, 1'b1);
        checkOutput("er_sticky", WW'(err), 96'd1);
        checkOutput("er_nwords", WW'(rd_data_q.size()), WW'(RD));
        check_frame("er", 60, 80, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("er_rst", WW'(err), '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a read discards the rest of the bank.
        $display("[TB] test: reset mid-read");
        clear_mon();
        applyStimulus(1'b1, make_beat(200), 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, make_beat(212), 1'b1, 1'b1);
        @(negedge clk);
        guard = 0;
        while (rd_data_q.size() < 5 && guard < 20) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            @(negedge clk);
            guard++;
        end
        checkOutput("mr_five", WW'(rd_data_q.size()), 96'd5);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("mr_mvalid", WW'(m_valid), '0);
        checkOutput("mr_full", WW'(bank_full), '0);
        checkOutput("mr_ren", WW'(ram_r_en), '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mr_sready", WW'(s_ready), 96'd1);
        clear_mon();
        applyStimulus(1'b1, make_beat(20), 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("mr_waddr0", WW'(ram_w_addr), 96'd0);
        applyStimulus(1'b1, make_beat(40), 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("mr_waddr1", WW'(ram_w_addr), 96'd1);
        idle(16, 1'b1);
        checkOutput("mr_naddr", WW'(ra_q.size()), WW'(RD));
        if (ra_q.size() > 0) checkOutput("mr_raddr0", WW'(ra_q[0]), 96'd0);
        check_frame("mr", 20, 40, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/asym_bram_pingpong_ctrl.md
# asym_bram_pingpong_ctrl

Controller that sequences a wide-write / narrow-read asymmetric simple-dual-port block RAM as a two-bank ping-pong buffer. The write side accepts frames of wide words over a valid/ready stream and fills one bank while the read side drains the other. The read side emits each bank as narrow words on a valid/ready stream. It sits between the wide weight/pixel fetch path and the narrow consumers. It drives the RAM's port A (write) and port B (read, 1-cycle registered output) directly.

## Interface
- R_WIDTH, 16: narrow read word width (bits).
- R_DEPTH, 12: narrow words per bank (frame).
- W_WIDTH, 96: wide write word width; R_WIDTH*R_DEPTH must be a multiple of W_WIDTH, and W_WIDTH a multiple of R_WIDTH.
- W_DEPTH, R_WIDTH*R_DEPTH/W_WIDTH (derived, 2): wide beats per frame.
- W_ADDR_WIDTH, $clog2(2*W_DEPTH); R_ADDR_WIDTH, $clog2(2*R_DEPTH) (derived).

Ports:
- clk  in  1  single clock, all logic posedge.
- rst  in  1  synchronous, active-high reset.
- s_valid / s_ready  in / out  1  write-stream handshake.
- s_data  in  W_WIDTH  wide word.
- s_last  in  1  frame-end marker, checked only.
- m_valid / m_ready  out / in  1  read-stream handshake.
- m_data  out  R_WIDTH  narrow word, wired from ram_r_data.
- m_last  out  1  last narrow word of a bank.
- ram_w_en  out  1  port A write enable.
- ram_w_addr  out  W_ADDR_WIDTH  port A address.
- ram_w_data  out  W_WIDTH  wired from s_data.
- ram_r_en  out  1  port B enable.
- ram_r_addr  out  R_ADDR_WIDTH  port B address.
- ram_r_data  in  R_WIDTH  port B registered output; holds while ram_r_en=0.
- bank_full  out  2  per-bank full flags.
- err  out  1  sticky s_last mismatch.

## Operation
- State:
  - full[1:0]
  - write bank wb, beat counter wc (0..W_DEPTH-1)
  - read bank rb, word counter rc (0..R_DEPTH-1)
  - m_valid, m_last, err registers
- Write side:
  - s_ready = !full[wb] && !rst.
  - Accept = s_valid && s_ready, and ram_w_en = accept.
  - ram_w_addr = wb*W_DEPTH + wc.
  - On accept: wc++. At wc==W_DEPTH-1: full[wb]<=1, wb<=~wb, wc<=0.
- Read issue:
  - issue = full[rb] && (!m_valid || m_ready) && !rst, and ram_r_en = issue.
  - ram_r_addr = rb*R_DEPTH + rc.
  - On issue: m_valid<=1, m_last<=(rc==R_DEPTH-1), rc++.
  - At rc==R_DEPTH-1: full[rb]<=0, rb<=~rb, rc<=0.
- Read output:
  - No issue && m_ready: m_valid<=0, m_last<=0.
  - No issue && !m_ready: hold. The RAM output holds because ram_r_en=0, so m_data is stable under backpressure.
- Lane order is the RAM's: narrow address k maps to wide word k/(W_WIDTH/R_WIDTH), lane k mod ratio, least-significant lane first. The controller never reorders.
- Error check: err<=1 on any accepted beat where s_last != (wc==W_DEPTH-1). Frame length is still counted by wc; s_last never terminates a frame. err clears only on rst.
- Same-bank set/clear in one cycle is impossible: a set requires full=0, a clear requires full=1. Set of one bank and clear of the other in the same cycle are both applied.
- Reset, including mid-frame:
  - Clears full, wb, wc, rb, rc, m_valid, m_last, err.
  - ram_w_en and ram_r_en are 0 while rst=1.
  - Partial frames are discarded.

## Timing
- Reset values: s_ready=0 during rst and 1 the first cycle after; m_valid=0, m_last=0, bank_full=0, err=0, ram_w_en=0, ram_r_en=0.
- Write throughput is 1 beat/cycle while a bank is free.
- Latency: last write beat accepted in cycle t → full set at t+1 → first issue at t+1 → m_valid=1 at t+2.
- Read throughput is 1 word/cycle with m_ready=1. A bank's R_DEPTH words occupy R_DEPTH consecutive cycles, and the next bank's first word follows with no bubble if it is full.
- A drained bank becomes writable (s_ready=1) the cycle after its last issue.
- With both banks full, s_ready=0 until a read drains one.

## Test plan
- Reset: hold rst 3 cycles with s_valid=1 → ram_w_en=0, s_ready=0, m_valid=0, bank_full=0, err=0. Cycle after release → s_ready=1.
- Single frame, defaults:
  - Stimulus: write beats bytes 10..21 then 30..41, s_last on beat 1, m_ready=1.
  - ram_w_addr = 0, 1.
  - m_valid 2 cycles after beat 1, then 12 consecutive words.
  - ram_r_addr = 0..11, words in RAM lane order, m_last only on word 11, err=0.
- Backpressure: m_ready toggles 1,0,0,1,… → ram_r_en=0 and m_data/m_last unchanged on every stalled cycle. All 12 words delivered once, in order.
- Ping-pong:
  - Stimulus: m_ready=0, offer 3 frames.
  - After 4 beats: bank_full=2'b11 and s_ready=0. Bank 1 writes at ram_w_addr 2,3.
  - Raise m_ready → bank 0 (addr 0..11) then bank 1 (addr 12..23) with no bubble.
  - s_ready=1 the cycle after addr 11 is issued; frame 3 writes to addr 0,1.
- s_last error: s_last=1 on beat 0 → err=1 from the next cycle and sticky. The frame still completes after 2 beats and is read normally. rst → err=0.
- Reset mid-read: assert rst after 5 of 12 words → m_valid=0, bank_full=0. The next frame writes ram_w_addr 0 and reads from ram_r_addr 0.
